// File: rtl/sound_voice.sv
`default_nettype none
// sound_voice: one note at a time, square-wave oscillator shaped by an attack/sustain/release
// envelope, rendered as 1-bit PWM against an external free-running carrier. Rev 1.0
module sound_voice #(
  parameter int BW      = 8,
  parameter int PW      = 16,
  parameter int LW      = 8,
  parameter int ENV_DIV = 256
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [BW-1:0] cnt_i,
  input  logic          note_valid_i,
  output logic          note_ready_o,
  input  logic [PW-1:0] note_period_i,
  input  logic [LW-1:0] note_len_i,
  output logic [BW-1:0] level_o,
  output logic          busy_o,
  output logic          audio_o
);

  localparam int            PSW     = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam logic [BW-1:0] MAX     = {BW{1'b1}};
  localparam logic [PSW-1:0] PS_LAST = PSW'(ENV_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [BW-1:0]  level, level_nxt;
  logic [LW-1:0]  len, len_nxt;
  logic [PW-1:0]  period, period_nxt;
  logic [PW-1:0]  phase, phase_nxt;
  logic [PSW-1:0] presc, presc_nxt;
  logic           sq, sq_nxt;
  logic           audio;
  logic [BW-1:0]  amp;
  logic           tick;
  logic           accept;

  assign note_ready_o = (state == IDLE);
  assign busy_o       = ~note_ready_o;
  assign level_o      = level;
  assign audio_o      = audio;
  assign accept       = note_valid_i && (state == IDLE);
  assign tick         = (state != IDLE) && (presc == PS_LAST);
  assign amp          = sq ? level : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    level_nxt  = level;
    len_nxt    = len;
    period_nxt = period;
    case (state)
      IDLE: begin
        level_nxt = '0;
        if (accept) begin
          state_nxt  = ATTACK;
          period_nxt = note_period_i;
          len_nxt    = note_len_i;
        end
      end
      ATTACK: if (tick) begin
        level_nxt = level + 1'b1;
        if (level == MAX - 1'b1) state_nxt = SUSTAIN;
      end
      SUSTAIN: if (tick) begin
        if (len == '0) state_nxt = RELEASE;
        else           len_nxt   = len - 1'b1;
      end
      RELEASE: if (tick) begin
        level_nxt = level - 1'b1;
        if (level == BW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Prescaler and oscillator restart from zero on every accept and are parked at zero in IDLE.
  always_comb begin
    presc_nxt = '0;
    phase_nxt = '0;
    sq_nxt    = 1'b0;
    if (state != IDLE && state_nxt != IDLE) begin
      presc_nxt = tick ? '0 : presc + 1'b1;
      phase_nxt = phase;
      sq_nxt    = sq;
      if (period != '0) begin
        if (phase == period - 1'b1) begin
          phase_nxt = '0;
          sq_nxt    = ~sq;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level  <= '0;
      len    <= '0;
      period <= '0;
      phase  <= '0;
      presc  <= '0;
      sq     <= 1'b0;
      audio  <= 1'b0;
    end else begin
      level  <= level_nxt;
      len    <= len_nxt;
      period <= period_nxt;
      phase  <= phase_nxt;
      presc  <= presc_nxt;
      sq     <= sq_nxt;
      audio  <= (amp > cnt_i);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sound_voice.sv
`default_nettype none
// tb_sound_voice: directed notes against a closed-form envelope/oscillator model, plus literal pins.
module tb_sound_voice;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cnt = '0;
  logic       note_valid = 1'b0;
  logic       note_ready;
  logic [7:0] note_period = '0;
  logic [3:0] note_len = '0;
  logic [3:0] level;
  logic       busy;
  logic       audio;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  sound_voice #(.BW(4), .PW(8), .LW(4), .ENV_DIV(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cnt_i        (cnt),
    .note_valid_i (note_valid),
    .note_ready_o (note_ready),
    .note_period_i(note_period),
    .note_len_i   (note_len),
    .level_o      (level),
    .busy_o       (busy),
    .audio_o      (audio)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 4'd1;
  always @(posedge clk) cyc <= cyc + 1;

  // Envelope as a function of cycles since acceptance: 15 ticks up, len+1 at top, 15 down.
  function automatic int f_level(input bit b, input int n, input int l);
    int k;
    if (!b) return 0;
    k = n / 4;
    if (k <= 15) return k;
    if (k <= 16 + l) return 15;
    return 15 - (k - 16 - l);
  endfunction

  function automatic int f_sq(input bit b, input int n, input int p);
    if (!b || p == 0) return 0;
    return (n / p) % 2;
  endfunction

  bit m_busy = 1'b0;
  int m_n = 0;
  int m_p = 0;
  int m_l = 0;
  bit m_audio = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_n     <= 0;
      m_p     <= 0;
      m_l     <= 0;
      m_audio <= 1'b0;
    end else begin
      m_audio <= ((f_sq(m_busy, m_n, m_p) != 0 ? f_level(m_busy, m_n, m_l) : 0) > int'(cnt));
      if (m_busy) begin
        m_n <= m_n + 1;
        if (m_n + 1 >= (31 + m_l) * 4) m_busy <= 1'b0;
      end else if (note_valid) begin
        m_busy <= 1'b1;
        m_n    <= 0;
        m_p    <= int'(note_period);
        m_l    <= int'(note_len);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      if (int'(level) != f_level(m_busy, m_n, m_l) || busy != m_busy ||
          note_ready != !m_busy || audio != m_audio) begin
        fails++;
        $display("FAIL cycle %0d: level=%0d busy=%0b ready=%0b audio=%0b, model level=%0d busy=%0b ready=%0b audio=%0b",
                 cyc, level, busy, note_ready, audio,
                 f_level(m_busy, m_n, m_l), m_busy, !m_busy, m_audio);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic after_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  int t0, t2, t3, t4, t5, t6;
  int bc, ac;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset level", int'(level), 0);
    check("reset busy", int'(busy), 0);
    check("reset ready", int'(note_ready), 1);
    check("reset audio", int'(audio), 0);
    rst_n = 1'b1;

    // Basic note, with a second note held on valid throughout.
    note_valid = 1'b1; note_period = 8'd3; note_len = 4'd2;
    @(posedge clk); #1; t0 = cyc;
    note_period = 8'd5; note_len = 4'd0;
    check("accept busy", int'(busy), 1);
    check("accept ready", int'(note_ready), 0);
    after_edge(t0 + 4);   check("first tick level", int'(level), 1);
    after_edge(t0 + 60);  check("attack top level", int'(level), 15);
    after_edge(t0 + 72);  check("last sustain level", int'(level), 15);
    after_edge(t0 + 76);  check("first release level", int'(level), 14);
    after_edge(t0 + 131); check("busy before end", int'(busy), 1);
    after_edge(t0 + 132);
    check("end busy", int'(busy), 0);
    check("end ready", int'(note_ready), 1);
    check("end level", int'(level), 0);
    after_edge(t0 + 133); t2 = cyc;
    note_valid = 1'b0;
    check("queued accept busy", int'(busy), 1);
    after_edge(t2 + 4);   check("queued first tick", int'(level), 1);
    after_edge(t2 + 124); check("queued end busy", int'(busy), 0);

    // Silent note.
    note_valid = 1'b1; note_period = 8'd0; note_len = 4'd0;
    @(posedge clk); #1; t3 = cyc;
    note_valid = 1'b0;
    bc = 0; ac = 0;
    for (int i = 0; i < 124; i++) begin
      after_edge(t3 + i);
      bc += int'(busy);
      ac += int'(audio);
    end
    check("silent busy cycles", bc, 124);
    check("silent audio highs", ac, 0);
    after_edge(t3 + 124); check("silent end busy", int'(busy), 0);

    // PWM duty in sustain with a long half-period.
    note_valid = 1'b1; note_period = 8'd60; note_len = 4'd15;
    @(posedge clk); #1; t4 = cyc;
    note_valid = 1'b0;
    ac = 0;
    for (int i = 65; i <= 80; i++) begin
      after_edge(t4 + i);
      ac += int'(audio);
    end
    check("pwm sq=1 highs", ac, 15);
    ac = 0;
    for (int i = 121; i <= 128; i++) begin
      after_edge(t4 + i);
      ac += int'(audio);
    end
    check("pwm sq=0 highs", ac, 0);
    after_edge(t4 + 184); check("pwm end busy", int'(busy), 0);

    // Asynchronous reset mid-sustain.
    note_valid = 1'b1; note_period = 8'd3; note_len = 4'd15;
    @(posedge clk); #1; t5 = cyc;
    note_valid = 1'b0;
    after_edge(t5 + 70);
    check("pre-reset level", int'(level), 15);
    #2 rst_n = 1'b0;
    #1;
    check("async level", int'(level), 0);
    check("async audio", int'(audio), 0);
    check("async busy", int'(busy), 0);
    check("async ready", int'(note_ready), 1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    note_valid = 1'b1; note_period = 8'd2; note_len = 4'd1;
    @(posedge clk); #1; t6 = cyc;
    note_valid = 1'b0;
    check("post-reset accept", int'(busy), 1);
    after_edge(t6 + 4);   check("post-reset first tick", int'(level), 1);
    after_edge(t6 + 128); check("post-reset end busy", int'(busy), 0);
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sound_voice.md
Name: sound_voice

Overview:
- Single-voice tone and envelope stage for the sound generator.
- Takes the free-running BW-bit counter value as its PWM carrier.
- Accepts one note at a time over a valid/ready handshake, generates a square wave shaped by an attack/sustain/release envelope, and drives a 1-bit PWM audio pin.
- Sits directly downstream of the counter and directly upstream of the output pad.

Parameters:
- BW, 8: width of the carrier counter and of the envelope level.
- PW, 16: width of the note half-period field.
- LW, 8: width of the sustain-length field.
- ENV_DIV, 256: clock cycles per envelope tick; must be at least 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cnt_i  in  BW  free-running carrier counter value
- note_valid_i  in  1  note request
- note_ready_o  out  1  voice can accept a note
- note_period_i  in  PW  square-wave half-period in clock cycles; 0 = silent
- note_len_i  in  LW  sustain length in envelope ticks, minus 1
- level_o  out  BW  current envelope level
- busy_o  out  1  note in progress
- audio_o  out  1  PWM audio output

Behaviour:
Reset and interface:
- One clock, clk_i. Reset rst_ni is asynchronous and active-low.
- While rst_ni = 0: state = IDLE, level_o = 0, audio_o = 0, busy_o = 0, note_ready_o = 1, and all internal counters are 0.
- Reset asserted mid-note aborts the note immediately, without waiting for a clock edge.

Handshake:
- note_ready_o = (state == IDLE); busy_o = !note_ready_o. Both are decoded from the state register.
- A note is accepted at a rising edge where note_valid_i and note_ready_o are both 1.
- On acceptance: period and length are latched, state goes to ATTACK, and the prescaler, phase counter, square bit and level are all cleared to 0.
- Requests made while busy are ignored. Inputs are not sampled again until the voice is back in IDLE.

Envelope prescaler:
- Counts 0..ENV_DIV-1 while state != IDLE, then wraps.
- An envelope tick is the cycle in which prescaler = ENV_DIV-1. The first tick falls ENV_DIV cycles after acceptance.

Envelope FSM (MAX = 2^BW - 1):
- IDLE: level = 0. Leaves only on acceptance.
- ATTACK: level += 1 on each tick. On the tick where level = MAX-1, level becomes MAX and state goes to SUSTAIN.
- SUSTAIN: level is held at MAX. On each tick: if len = 0, go to RELEASE; otherwise len -= 1. This gives exactly note_len_i + 1 ticks of sustain.
- RELEASE: level -= 1 on each tick. On the tick where level = 1, level becomes 0 and state goes to IDLE.
- Note duration from acceptance to busy_o falling is (2*MAX + note_len_i + 1) * ENV_DIV cycles.
- Level never wraps in either direction.

Oscillator:
- Active in any state other than IDLE, and only when period != 0.
- Each cycle: if phase = period-1, phase <= 0 and sq <= ~sq; otherwise phase += 1. This gives a full square-wave period of 2*period cycles, starting with sq = 0.
- When period = 0, sq stays 0. In IDLE, phase and sq are held at 0.

PWM output:
- amp = sq ? level : 0.
- audio_o is registered: audio_o <= (amp > cnt_i), unsigned compare.
- Latency is 1 cycle from cnt_i, sq and level to audio_o.
- amp = 0 gives a constant 0; amp = MAX gives 2^BW - 1 high cycles per 2^BW carrier counts.

Test Plan:
All scenarios use BW=4, PW=8, LW=4, ENV_DIV=4, with cnt_i driven by a free-running 4-bit counter.
- Basic note: period=3, len=2 accepted at edge T. level_o reads 1 after T+4 and 15 after T+60. SUSTAIN covers 3 ticks (12 cycles). level_o returns to 0 and busy_o falls at T+132, and note_ready_o rises in the same cycle.
- Oscillator: period=3 during ATTACK. sq (observed via audio_o gating) toggles every 3 cycles, giving a period of 6. Phase and sq restart at 0 on every new note.
- PWM duty: in SUSTAIN (level=15) while sq=1, audio_o is high for 15 of 16 cnt_i values, one cycle after each value. Whenever sq=0, or in IDLE, audio_o stays 0.
- Silent note: period=0, len=0. The envelope runs the full (2*15 + 1) * 4 = 124 cycles with busy_o = 1, while audio_o stays 0 throughout.
- Handshake: note_valid_i held high with a second note queued during a note. note_ready_o is 0 and the second note is not accepted. It is accepted at the first edge where note_ready_o = 1, and its latched period differs from the first note.
- Async reset: pull rst_ni low mid-SUSTAIN, between clock edges. level_o=0, audio_o=0, busy_o=0 and note_ready_o=1 immediately. After release, a new note is accepted on the next valid edge.
